clock_alarm_multi: RTL and testbench
====================================

# clock_alarm_multi

Parametrised multi-alarm digital clock: a prescaler turns the system clock into a 1 s tick that drives BCD seconds/minutes/hours counters. NUM_ALARMS independent alarm registers are compared against the time. A ring/snooze/timeout state machine drives the alarm output. Six 7-segment digit buses display either the time or the selected alarm, in 24 h or 12 h format. It replaces the single-alarm clock at the board top level, between the debounced push-buttons and the display pins.

## Interface
- TICKS_PER_SEC, 50_000_000, clk cycles per second (≥2)
- NUM_ALARMS, 2, number of alarm registers (1..4)
- SNOOZE_MIN, 5, snooze length in minutes (1..59)
- RING_TIMEOUT_S, 60, seconds of unattended ringing before auto-stop (1..255)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- Set_Clock  in  1  level; time-set mode while high
- Set_Alarm  in  1  level; alarm-set/display mode while high
- Alarm_Sel  in  max(1,clog2(NUM_ALARMS))  alarm index for set/display
- Alarm_En  in  NUM_ALARMS  per-alarm enable, level
- MIN  in  1  increment minutes (rising edge)
- HR  in  1  increment hours (rising edge)
- Snooze  in  1  snooze request (rising edge)
- Alarm_Off  in  1  stop alarm (rising edge)
- Mode_12h  in  1  1 = 12 h display, 0 = 24 h
- seg_s_u, seg_s_t, seg_m_u, seg_m_t, seg_h_u, seg_h_t  out  7 each  digit segments {a,b,c,d,e,f,g}, bit6=a, 1=lit
- pm  out  1  12 h mode and displayed hour ≥12
- alarm_ring  out  1  alarm sounding
- ring_id  out  max(1,clog2(NUM_ALARMS))  alarm that triggered the current ring/snooze

## Operation
- Reset values: time 00:00:00, all alarms 00:00, prescaler 0, FSM IDLE, edge registers 0, alarm_ring 0, ring_id 0, pm 0, every seg = 7'b1111110 ("0").
- Prescaler counts 0..TICKS_PER_SEC-1. sec_tick is asserted on the wrap. Seconds 0..59 wraps into minutes. Minutes 0..59 wraps into hours. Hours 0..23 wraps to 0. All counts are internally 24 h BCD.
- Edge detect: MIN, HR, Snooze and Alarm_Off each have a previous-sample register. An event is defined as input=1 && prev=0.
- Set_Clock=1 has priority over Set_Alarm:
  - Prescaler and seconds are held at 0.
  - MIN increments minutes mod 60 with no carry into hours. HR increments hours mod 24.
  - Alarm matching is suppressed.
- Set_Alarm=1 with Set_Clock=0:
  - Time keeps running.
  - Display shows alarm[Alarm_Sel] as hh:mm, with seconds digits showing 00.
  - MIN/HR increment that alarm's minutes mod 60 and hours mod 24 independently.
  - Alarm_Sel ≥ NUM_ALARMS is ignored: display shows the time and no write occurs.
- Match: on the sec_tick that makes seconds 00, for each alarm with Alarm_En=1 and hh:mm equal to the new time. The lowest matching index wins.
- FSM:
  - IDLE → RING on a match. ring_id is loaded and the ring-second counter is cleared.
  - RING → IDLE on an Alarm_Off event, or when the ring-second counter reaches RING_TIMEOUT_S.
  - RING → SNOOZE on a Snooze event. The snooze-second counter is loaded with SNOOZE_MIN·60.
  - SNOOZE: counter decrements on sec_tick. At 0 → RING with the ring counter cleared. An Alarm_Off event → IDLE.
  - Matches are ignored outside IDLE.
  - Simultaneous Alarm_Off and Snooze: Alarm_Off wins.
- alarm_ring = (state == RING).
- 12 h display: hour 0 → 12, 1..12 → same, 13..23 → h−12. pm = (hour ≥ 12) && Mode_12h. In alarm display, pm refers to the alarm hour.
- 7-segment map (abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Reset low mid-ring or mid-set returns every register to its reset value at the next edge.

## Timing
- Counters and FSM are registered. seg/pm/alarm_ring are combinational from registers and change in the same cycle as the registers.
- Time advances exactly once every TICKS_PER_SEC cycles. The first sec_tick occurs TICKS_PER_SEC cycles after reset release.
- Button latency: the increment or FSM move happens at the first clock edge that samples the input high. It is visible one cycle later. A held input gives only one event.
- alarm_ring rises at the same edge at which seconds become 00 on a matching minute.
- Leaving Set_Clock: the prescaler restarts from 0. The next second elapses after a full TICKS_PER_SEC cycles.

## Test plan
- Reset held 3 cycles, then released → all segs 1111110, alarm_ring=0. After 4·TICKS_PER_SEC cycles (TICKS_PER_SEC=4), seg_s_u = 0110011 ("4").
- Set time 23:59:59 via Set_Clock (HR ×23, MIN ×59), release, run to 59 s, then one more second → display 00:00:00 with no spurious alarm.
- Set_Clock=1 and one HR event → hours 01, seconds stay 00 for 100 cycles, minutes unchanged. Add 60 MIN events → minutes back at 00 and hours still 01.
- NUM_ALARMS=2: alarm1=00:02, Alarm_En=2'b10, alarm0=00:02 disabled. Run from 00:00:00 → at 00:02:00, alarm_ring=1 and ring_id=1. With no action, alarm_ring falls after RING_TIMEOUT_S seconds.
- SNOOZE_MIN=1, ringing at 00:02:00, Snooze at 00:02:05 → alarm_ring=0, re-rings at 00:03:05. Alarm_Off and Snooze in the same cycle → IDLE, with no re-ring after 60 s.
- Mode_12h=1: time 13:00 → hour digits "01", pm=1. Time 00:xx → "12", pm=0. Alarm_Sel=3 with NUM_ALARMS=2 and Set_Alarm=1 → time is displayed and MIN changes no alarm.

Source files
------------

// File: rtl/clock_alarm_multi_if.sv
// Button/display bundle of the multi-alarm clock.
// master = push-button/board side, slave = clock core.
interface clock_alarm_multi_if #(
  parameter int NUM_ALARMS = 2
) ();
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                  Set_Clock;
  logic                  Set_Alarm;
  logic [SEL_W-1:0]      Alarm_Sel;
  logic [NUM_ALARMS-1:0] Alarm_En;
  logic                  MIN;
  logic                  HR;
  logic                  Snooze;
  logic                  Alarm_Off;
  logic                  Mode_12h;
  logic [6:0]            seg_s_u;
  logic [6:0]            seg_s_t;
  logic [6:0]            seg_m_u;
  logic [6:0]            seg_m_t;
  logic [6:0]            seg_h_u;
  logic [6:0]            seg_h_t;
  logic                  pm;
  logic                  alarm_ring;
  logic [SEL_W-1:0]      ring_id;

  modport master (
    output Set_Clock, Set_Alarm, Alarm_Sel, Alarm_En, MIN, HR, Snooze, Alarm_Off, Mode_12h,
    input  seg_s_u, seg_s_t, seg_m_u, seg_m_t, seg_h_u, seg_h_t, pm, alarm_ring, ring_id
  );

  modport slave (
    input  Set_Clock, Set_Alarm, Alarm_Sel, Alarm_En, MIN, HR, Snooze, Alarm_Off, Mode_12h,
    output seg_s_u, seg_s_t, seg_m_u, seg_m_t, seg_h_u, seg_h_t, pm, alarm_ring, ring_id
  );
endinterface

// File: rtl/clock_alarm_multi.sv
// Multi-alarm BCD clock: 1 s prescaler, hh:mm:ss counters, NUM_ALARMS
// alarm registers, ring/snooze/timeout FSM and 6-digit 7-segment output.
module clock_alarm_multi #(
  parameter int TICKS_PER_SEC  = 50_000_000,
  parameter int NUM_ALARMS     = 2,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic               clk,
  input  logic               reset,
  clock_alarm_multi_if.slave bus
);
  localparam int               SEL_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int               PRE_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [SEL_W:0]   NUM_AL_C  = (SEL_W + 1)'(NUM_ALARMS);
  localparam logic [11:0]      SNZ_LOAD  = 12'(SNOOZE_MIN * 60);
  localparam logic [7:0]       RING_LAST = 8'(RING_TIMEOUT_S - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RING = 2'd1, ST_SNOOZE = 2'd2} state_t;

  // BCD increment that wraps to 00 after 'last'
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last) return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // 24 h BCD hour to 12 h BCD hour (00 -> 12, 13..23 -> 01..11)
  function automatic logic [7:0] to_12h(input logic [7:0] h);
    if (h == 8'h00) return 8'h12;
    else begin
      case (h)
        8'h13: return 8'h01;
        8'h14: return 8'h02;
        8'h15: return 8'h03;
        8'h16: return 8'h04;
        8'h17: return 8'h05;
        8'h18: return 8'h06;
        8'h19: return 8'h07;
        8'h20: return 8'h08;
        8'h21: return 8'h09;
        8'h22: return 8'h10;
        8'h23: return 8'h11;
        default: return h;
      endcase
    end
  endfunction

  // BCD digit to segments {a..g}, blank for non-decimal codes
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  logic [PRE_W-1:0] presc_r;
  logic [7:0]       sec_r, min_r, hr_r;
  logic [7:0]       alarm_h_r [NUM_ALARMS];
  logic [7:0]       alarm_m_r [NUM_ALARMS];
  logic             min_prev_r, hr_prev_r, snz_prev_r, off_prev_r;
  state_t           state_r;
  logic [7:0]       ring_cnt_r;
  logic [11:0]      snz_cnt_r;
  logic [SEL_W-1:0] ring_id_r;

  logic             min_ev_s, hr_ev_s, snz_ev_s, off_ev_s;
  logic             sec_tick_s, tm_wrap_s, sel_ok_s;
  logic [7:0]       nxt_min_s, nxt_hr_s;
  logic             match_any_s;
  logic [SEL_W-1:0] match_id_s;
  logic [7:0]       sel_h_s, sel_m_s, disp_h_s, disp_m_s, disp_s_s, shown_h_s;
  logic             pm_s;

  // Button events, second tick and the time value after a minute rollover
  always_comb begin
    min_ev_s   = bus.MIN & ~min_prev_r;
    hr_ev_s    = bus.HR & ~hr_prev_r;
    snz_ev_s   = bus.Snooze & ~snz_prev_r;
    off_ev_s   = bus.Alarm_Off & ~off_prev_r;
    sec_tick_s = ~bus.Set_Clock && (presc_r == PRE_LAST);
    tm_wrap_s  = sec_tick_s && (sec_r == 8'h59);
    sel_ok_s   = bus.Set_Alarm && ~bus.Set_Clock && ({1'b0, bus.Alarm_Sel} < NUM_AL_C);
    if (sec_r == 8'h59) begin
      nxt_min_s = bcd_inc(min_r, 8'h59);
      nxt_hr_s  = (min_r == 8'h59) ? bcd_inc(hr_r, 8'h23) : hr_r;
    end else begin
      nxt_min_s = min_r;
      nxt_hr_s  = hr_r;
    end
  end

  // Alarm compare against the time about to be loaded; lowest index wins
  always_comb begin
    match_any_s = 1'b0;
    match_id_s  = {SEL_W{1'b0}};
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (tm_wrap_s && bus.Alarm_En[i] && (alarm_h_r[i] == nxt_hr_s) && (alarm_m_r[i] == nxt_min_s)) begin
        match_any_s = 1'b1;
        match_id_s  = SEL_W'(i);
      end else begin
        match_any_s = match_any_s;
        match_id_s  = match_id_s;
      end
    end
  end

  // Display source select (time or selected alarm) and 12 h conversion
  always_comb begin
    sel_h_s = 8'h00;
    sel_m_s = 8'h00;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      sel_h_s = (bus.Alarm_Sel == SEL_W'(i)) ? alarm_h_r[i] : sel_h_s;
      sel_m_s = (bus.Alarm_Sel == SEL_W'(i)) ? alarm_m_r[i] : sel_m_s;
    end
    if (sel_ok_s) begin
      disp_h_s = sel_h_s;
      disp_m_s = sel_m_s;
      disp_s_s = 8'h00;
    end else begin
      disp_h_s = hr_r;
      disp_m_s = min_r;
      disp_s_s = sec_r;
    end
    if (bus.Mode_12h) shown_h_s = to_12h(disp_h_s);
    else shown_h_s = disp_h_s;
    pm_s = bus.Mode_12h && (disp_h_s >= 8'h12);
  end

  // Prescaler and time-of-day counters, including time-set mode
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_r <= {PRE_W{1'b0}};
      sec_r   <= 8'h00;
      min_r   <= 8'h00;
      hr_r    <= 8'h00;
    end else if (bus.Set_Clock) begin
      presc_r <= {PRE_W{1'b0}};
      sec_r   <= 8'h00;
      if (min_ev_s) min_r <= bcd_inc(min_r, 8'h59);
      if (hr_ev_s)  hr_r  <= bcd_inc(hr_r, 8'h23);
    end else if (sec_tick_s) begin
      presc_r <= {PRE_W{1'b0}};
      sec_r   <= bcd_inc(sec_r, 8'h59);
      min_r   <= nxt_min_s;
      hr_r    <= nxt_hr_s;
    end else begin
      presc_r <= presc_r + {{(PRE_W-1){1'b0}}, 1'b1};
    end
  end

  // Alarm registers, written only in alarm-set mode with a valid index
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (!reset) begin
        alarm_h_r[i] <= 8'h00;
        alarm_m_r[i] <= 8'h00;
      end else if (sel_ok_s && (bus.Alarm_Sel == SEL_W'(i))) begin
        if (min_ev_s) alarm_m_r[i] <= bcd_inc(alarm_m_r[i], 8'h59);
        if (hr_ev_s)  alarm_h_r[i] <= bcd_inc(alarm_h_r[i], 8'h23);
      end
    end
  end

  // Previous-sample registers for button edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      min_prev_r <= 1'b0;
      hr_prev_r  <= 1'b0;
      snz_prev_r <= 1'b0;
      off_prev_r <= 1'b0;
    end else begin
      min_prev_r <= bus.MIN;
      hr_prev_r  <= bus.HR;
      snz_prev_r <= bus.Snooze;
      off_prev_r <= bus.Alarm_Off;
    end
  end

  // Ring/snooze/timeout state machine; Alarm_Off beats Snooze
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      ring_cnt_r <= 8'd0;
      snz_cnt_r  <= 12'd0;
      ring_id_r  <= {SEL_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (match_any_s) begin
            state_r    <= ST_RING;
            ring_id_r  <= match_id_s;
            ring_cnt_r <= 8'd0;
          end
        end
        ST_RING: begin
          if (off_ev_s) begin
            state_r <= ST_IDLE;
          end else if (snz_ev_s) begin
            state_r   <= ST_SNOOZE;
            snz_cnt_r <= SNZ_LOAD;
          end else if (sec_tick_s) begin
            if (ring_cnt_r == RING_LAST) state_r <= ST_IDLE;
            else ring_cnt_r <= ring_cnt_r + 8'd1;
          end
        end
        ST_SNOOZE: begin
          if (off_ev_s) begin
            state_r <= ST_IDLE;
          end else if (sec_tick_s) begin
            if (snz_cnt_r <= 12'd1) begin
              state_r    <= ST_RING;
              ring_cnt_r <= 8'd0;
              snz_cnt_r  <= 12'd0;
            end else begin
              snz_cnt_r <= snz_cnt_r - 12'd1;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.seg_s_u    = seg7(disp_s_s[3:0]);
  assign bus.seg_s_t    = seg7(disp_s_s[7:4]);
  assign bus.seg_m_u    = seg7(disp_m_s[3:0]);
  assign bus.seg_m_t    = seg7(disp_m_s[7:4]);
  assign bus.seg_h_u    = seg7(shown_h_s[3:0]);
  assign bus.seg_h_t    = seg7(shown_h_s[7:4]);
  assign bus.pm         = pm_s;
  assign bus.alarm_ring = (state_r == ST_RING);
  assign bus.ring_id    = ring_id_r;
endmodule

// File: tb/tb_clock_alarm_multi.sv
// Scoreboard bench for clock_alarm_multi with a small time/alarm model.
module tb_clock_alarm_multi;
  localparam int T    = 4;
  localparam int NA   = 3;
  localparam int SNZM = 1;
  localparam int RTO  = 10;

  logic clk;
  logic reset;

  clock_alarm_multi_if #(.NUM_ALARMS(NA)) bus ();

  clock_alarm_multi #(
    .TICKS_PER_SEC(T), .NUM_ALARMS(NA), .SNOOZE_MIN(SNZM), .RING_TIMEOUT_S(RTO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         sel;
    logic [6:0] exp;
  } exp_t;

  exp_t       sb [$];
  int         vectors = 0;
  int         miscompares = 0;
  int         tsec = 0;
  int         ph = 0;
  int         al_h [4] = '{0, 0, 0, 0};
  int         al_m [4] = '{0, 0, 0, 0};
  logic [6:0] seg_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] obs(input int sel);
    case (sel)
      0: return bus.seg_s_u;
      1: return bus.seg_s_t;
      2: return bus.seg_m_u;
      3: return bus.seg_m_t;
      4: return bus.seg_h_u;
      5: return bus.seg_h_t;
      6: return {6'd0, bus.pm};
      7: return {6'd0, bus.alarm_ring};
      8: return {5'd0, bus.ring_id};
      default: return 7'd0;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [6:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, {25'd0, obs(e.sel)}, {25'd0, e.exp});
    end
  endtask

  // Advance n clocks, mirroring the expected timekeeping in the model.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!reset) begin
        tsec = 0;
        ph   = 0;
        for (int k = 0; k < 4; k++) begin
          al_h[k] = 0;
          al_m[k] = 0;
        end
      end else if (bus.Set_Clock) begin
        ph   = 0;
        tsec = tsec - (tsec % 60);
      end else begin
        ph++;
        if (ph == T) begin
          ph   = 0;
          tsec = (tsec + 1) % 86400;
        end
      end
    end
    #1;
  endtask

  // which: 0 = MIN, 1 = HR
  task automatic press(input int which, input int count);
    int h, m, sel;
    for (int c = 0; c < count; c++) begin
      if (which == 0) bus.MIN = 1'b1;
      else bus.HR = 1'b1;
      step(1);
      sel = int'(bus.Alarm_Sel);
      if (bus.Set_Clock) begin
        h = tsec / 3600;
        m = (tsec / 60) % 60;
        if (which == 0) m = (m + 1) % 60;
        else h = (h + 1) % 24;
        tsec = h * 3600 + m * 60;
      end else if (bus.Set_Alarm && sel < NA) begin
        if (which == 0) al_m[sel] = (al_m[sel] + 1) % 60;
        else al_h[sel] = (al_h[sel] + 1) % 24;
      end
      bus.MIN = 1'b0;
      bus.HR  = 1'b0;
      step(1);
    end
  endtask

  task automatic push_disp(input string tag);
    int h, m, s, sel;
    logic p;
    sel = int'(bus.Alarm_Sel);
    if (!bus.Set_Clock && bus.Set_Alarm && sel < NA) begin
      h = al_h[sel];
      m = al_m[sel];
      s = 0;
    end else begin
      h = tsec / 3600;
      m = (tsec / 60) % 60;
      s = tsec % 60;
    end
    p = bus.Mode_12h && (h >= 12);
    if (bus.Mode_12h) h = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
    push({tag, ".s_u"}, 0, seg_tbl[s % 10]);
    push({tag, ".s_t"}, 1, seg_tbl[s / 10]);
    push({tag, ".m_u"}, 2, seg_tbl[m % 10]);
    push({tag, ".m_t"}, 3, seg_tbl[m / 10]);
    push({tag, ".h_u"}, 4, seg_tbl[h % 10]);
    push({tag, ".h_t"}, 5, seg_tbl[h / 10]);
    push({tag, ".pm"}, 6, {6'd0, p});
  endtask

  task automatic push_ring(input string tag, input logic ring, input int id);
    push({tag, ".ring"}, 7, {6'd0, ring});
    if (ring) push({tag, ".ring_id"}, 8, 7'(id));
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (tsec != target && guard < 20000) begin
      step(1);
      guard++;
    end
    if (tsec != target) check_val("run_to_timeout", 32'(tsec), 32'(target));
  endtask

  initial begin
    reset         = 1'b0;
    bus.Set_Clock = 1'b0;
    bus.Set_Alarm = 1'b0;
    bus.Alarm_Sel = 2'd0;
    bus.Alarm_En  = 3'b000;
    bus.MIN       = 1'b0;
    bus.HR        = 1'b0;
    bus.Snooze    = 1'b0;
    bus.Alarm_Off = 1'b0;
    bus.Mode_12h  = 1'b0;

    // Reset and first seconds
    step(3);
    push_disp("reset");
    push_ring("reset", 1'b0, 0);
    push("reset.ring_id0", 8, 7'd0);
    drain();
    reset = 1'b1;
    step(4 * T);
    push("four_sec", 0, 7'b0110011);
    push_disp("four_sec");
    drain();

    // Time-set: held HR gives one event, seconds stay 00, no minute carry
    bus.Set_Clock = 1'b1;
    step(1);
    bus.HR = 1'b1;
    step(1);
    tsec = tsec - (tsec % 60) + 3600;
    step(2);
    bus.HR = 1'b0;
    step(1);
    push_disp("hr_held");
    drain();
    step(100);
    push_disp("set_hold100");
    drain();
    press(0, 60);
    push_disp("min60_nocarry");
    drain();

    // 12 h display
    bus.Mode_12h = 1'b1;
    step(1);
    push_disp("12h_01");
    drain();
    press(1, 12);
    push_disp("12h_13");
    push("12h_13.pm_hi", 6, 7'd1);
    drain();
    press(1, 11);
    push_disp("12h_00");
    push("12h_00.h_t", 5, 7'b0110000);
    drain();
    bus.Mode_12h = 1'b0;

    // 23:59:59 rollover
    press(1, 23);
    press(0, 59);
    push_disp("set_2359");
    drain();
    bus.Set_Clock = 1'b0;
    step(59 * T);
    push_disp("at_235959");
    drain();
    step(T);
    push_disp("rollover");
    push_ring("rollover", 1'b0, 0);
    drain();

    // Alarm programming, including an out-of-range selector
    bus.Set_Alarm = 1'b1;
    bus.Alarm_Sel = 2'd1;
    step(1);
    push_disp("al1_init");
    drain();
    press(0, 2);
    push_disp("al1_set");
    drain();
    bus.Alarm_Sel = 2'd0;
    press(0, 2);
    push_disp("al0_set");
    drain();
    bus.Alarm_Sel = 2'd3;
    step(1);
    push_disp("sel3_time");
    drain();
    press(0, 1);
    push_disp("sel3_after_min");
    drain();
    bus.Alarm_Sel = 2'd2;
    step(1);
    push_disp("al2_untouched");
    drain();
    bus.Alarm_Sel = 2'd0;
    step(1);
    push_disp("al0_kept");
    drain();
    bus.Set_Alarm = 1'b0;

    // Ring with only alarm 1 enabled, then timeout
    bus.Set_Clock = 1'b1;
    step(1);
    bus.Set_Clock = 1'b0;
    bus.Alarm_En  = 3'b010;
    run_to(119);
    push_ring("pre_match", 1'b0, 0);
    drain();
    run_to(120);
    push_disp("match_time");
    push_ring("match", 1'b1, 1);
    drain();
    run_to(120 + RTO - 1);
    push_ring("before_timeout", 1'b1, 1);
    drain();
    run_to(120 + RTO);
    push_ring("timeout", 1'b0, 0);
    drain();

    // Snooze path, both alarms match so index 0 wins
    bus.Set_Clock = 1'b1;
    press(0, 59);
    bus.Set_Clock = 1'b0;
    bus.Alarm_En  = 3'b011;
    run_to(120);
    push_ring("ring2", 1'b1, 0);
    drain();
    run_to(125);
    bus.Snooze = 1'b1;
    step(1);
    bus.Snooze = 1'b0;
    step(1);
    push_ring("snoozed", 1'b0, 0);
    drain();
    run_to(184);
    push_ring("snooze_pre", 1'b0, 0);
    drain();
    run_to(185);
    push_ring("rering", 1'b1, 0);
    drain();
    bus.Snooze    = 1'b1;
    bus.Alarm_Off = 1'b1;
    step(1);
    bus.Snooze    = 1'b0;
    bus.Alarm_Off = 1'b0;
    step(1);
    push_ring("off_wins", 1'b0, 0);
    drain();
    run_to(250);
    push_ring("no_rering", 1'b0, 0);
    drain();

    // Reset while ringing
    bus.Set_Clock = 1'b1;
    press(0, 57);
    bus.Set_Clock = 1'b0;
    bus.Alarm_En  = 3'b001;
    run_to(120);
    push_ring("ring3", 1'b1, 0);
    drain();
    reset = 1'b0;
    step(1);
    push_disp("mid_ring_reset");
    push_ring("mid_ring_reset", 1'b0, 0);
    drain();
    reset = 1'b1;
    bus.Set_Alarm = 1'b1;
    step(1);
    push_disp("al0_after_reset");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
